ps2_cmd_ctrl: RTL and testbench

Command controller that sequences host-to-device PS/2 transfers and shares the single PS/2 writer between two requesters. It arbitrates the requesters, launches the writer, then waits for the device's acknowledge byte from the PS/2 receive path. It retries on a resend request or a timeout, and returns a done/error pulse to the granted requester. It sits between the PS/2 writer/reader pair and the blocks that issue device commands (init sequencer on port 0, user/control logic on port 1).

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_cmd_ctrl_if.sv | 32 +++
 rtl/ps2_cmd_ctrl_counter.sv | 27 ++
 rtl/ps2_cmd_ctrl.sv | 146 ++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the command controller.
//   PS2_ACK     : device acknowledge byte
//   PS2_RESEND  : device resend-request byte
//   cmd_state_t : command controller state enumeration
package ps2_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ACCEPT,
    WAIT_TX,
    WAIT_ACK,
    FINISH
  } cmd_state_t;

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// PS/2 writer/reader bus between the command controller and the PS/2 PHY.
//   wr_ps2  : one-cycle launch strobe to the writer
//   cmd     : byte to transmit
//   tx_idle : writer idle flag
//   rx_done : one-cycle pulse, device byte received
//   rx_data : received byte, valid with rx_done
// master = command controller side, slave = writer/reader side.
interface ps2_cmd_ctrl_if;

  logic       wr_ps2;
  logic [7:0] cmd;
  logic       tx_idle;
  logic       rx_done;
  logic [7:0] rx_data;

  modport master (
    output wr_ps2,
    output cmd,
    input  tx_idle,
    input  rx_done,
    input  rx_data
  );

  modport slave (
    input  wr_ps2,
    input  cmd,
    output tx_idle,
    output rx_done,
    output rx_data
  );

endinterface

// File: rtl/ps2_cmd_ctrl_counter.sv
// Saturating up-counter used as the acknowledge timeout timer.
//   clk  : system clock
//   rst  : synchronous active-high clear (count returns to 0)
//   full : high while the count has reached MAX; the count holds there
module Counter #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst,
  output logic full
);

  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count != W'(MAX)) begin
      count <= count + W'(1);
    end
  end

  assign full = (count == W'(MAX));

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command controller.
// Arbitrates two command requesters (port 0 high priority), launches the
// shared PS/2 writer, waits for the device acknowledge, retries on resend
// or acknowledge timeout, and returns a one-cycle done/err pulse to the
// granted port.
//   clk, rst           : clock, synchronous active-low reset
//   req0/cmd0/done0/err0 : port 0 (init sequencer), high priority
//   req1/cmd1/done1/err1 : port 1 (user/control logic), low priority
//   busy               : high whenever the controller is not idle
//   bus                : writer/reader bus (wr_ps2, cmd, tx_idle, rx_done, rx_data)
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1_250_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] cmd0,
  output logic       done0,
  output logic       err0,
  input  logic       req1,
  input  logic [7:0] cmd1,
  output logic       done1,
  output logic       err1,
  output logic       busy,
  ps2_cmd_ctrl_if.master bus
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cmd_state_t         state;
  logic [RETRY_W-1:0] retry;
  logic               grant;     // 0 = port 0, 1 = port 1
  logic               wr_q;
  logic [7:0]         cmd_q;
  logic               timer_clr;
  logic               timeout;

  // The timer is held clear in IDLE, LAUNCH and FINISH, so it starts from
  // zero on the strobe cycle and counts cycles since wr_ps2.
  assign timer_clr = !rst || !(state inside {ACCEPT, WAIT_TX, WAIT_ACK});

  Counter #(
    .MAX(ACK_TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (timer_clr),
    .full(timeout)
  );

  assign bus.wr_ps2 = wr_q;
  assign bus.cmd    = cmd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      retry <= '0;
      grant <= 1'b0;
      wr_q  <= 1'b0;
      cmd_q <= '0;
      done0 <= 1'b0;
      err0  <= 1'b0;
      done1 <= 1'b0;
      err1  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      done0 <= 1'b0;
      err0  <= 1'b0;
      done1 <= 1'b0;
      err1  <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant <= !req0;
            cmd_q <= req0 ? cmd0 : cmd1;
            retry <= '0;
            busy  <= 1'b1;
            state <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (bus.tx_idle) begin
            wr_q  <= 1'b1;
            state <= ACCEPT;
          end
        end

        // A timeout before the frame is out means the bus clock is stuck;
        // resending cannot help, so fail straight away.
        ACCEPT: begin
          if (timeout) begin
            err0  <= !grant;
            err1  <= grant;
            state <= FINISH;
          end else if (!bus.tx_idle) begin
            state <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (timeout) begin
            err0  <= !grant;
            err1  <= grant;
            state <= FINISH;
          end else if (bus.tx_idle) begin
            state <= WAIT_ACK;
          end
        end

        // Acknowledge is checked first so it wins over a coincident timeout.
        WAIT_ACK: begin
          if (bus.rx_done && bus.rx_data == PS2_ACK) begin
            done0 <= !grant;
            done1 <= grant;
            state <= FINISH;
          end else if ((bus.rx_done && bus.rx_data == PS2_RESEND) || timeout) begin
            if (retry < RETRY_W'(MAX_RETRY)) begin
              retry <= retry + RETRY_W'(1);
              state <= LAUNCH;
            end else begin
              err0  <= !grant;
              err1  <= grant;
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl with a writer/device model and a
// transaction-level reference model of the retry policy.
module tb_ps2_cmd_ctrl;

  localparam int T      = 1000;
  localparam int MR     = 3;
  localparam int BUDGET = 6000;

  localparam int C_SIL  = 0;  // device silent
  localparam int C_ACK  = 1;  // 0xFA
  localparam int C_RES  = 2;  // 0xFE
  localparam int C_JACK = 3;  // junk byte, then 0xFA
  localparam int C_JRES = 4;  // junk byte, then 0xFE

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] cmd0 = '0, cmd1 = '0;
  logic       done0, err0, done1, err1, busy;

  ps2_cmd_ctrl_if bus ();

  ps2_cmd_ctrl #(
    .ACK_TIMEOUT(T),
    .MAX_RETRY  (MR)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .cmd0 (cmd0),
    .done0(done0),
    .err0 (err0),
    .req1 (req1),
    .cmd1 (cmd1),
    .done1(done1),
    .err1 (err1),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus controls (written by the main block only)
  int script[8];
  int script_len = 0;
  int script_base = 0;
  int frame_len = 200;
  bit stuck = 1'b0;
  bit stray = 1'b0;
  int inject_cnt = 0;

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [7:0] launch_q[$];
  int         launch_cyc[$];
  int         ev_q[$];        // 0 done0, 1 done1, 2 err0, 3 err1
  int         wr_double = 0;
  int         pulse_long = 0;
  logic       wr_prev = 1'b0;
  logic       out_prev = 1'b0;
  int         last_ack_cyc = -1;
  int         last_done_cyc = -1;
  int         last_err_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_ps2) begin
      launch_q.push_back(bus.cmd);
      launch_cyc.push_back(cyc);
      if (wr_prev) wr_double++;
    end
    wr_prev = bus.wr_ps2;
    if (bus.rx_done && bus.rx_data == 8'hFA) last_ack_cyc = cyc;
    if (done0) ev_q.push_back(0);
    if (done1) ev_q.push_back(1);
    if (err0)  ev_q.push_back(2);
    if (err1)  ev_q.push_back(3);
    if (done0 || done1) last_done_cyc = cyc;
    if (err0 || err1) last_err_cyc = cyc;
    if ((done0 || done1 || err0 || err1) && out_prev) pulse_long++;
    out_prev = done0 || done1 || err0 || err1;
  end

  // ---------------- writer + device model ----------------
  int frames = 0;
  int inject_seen = 0;

  task automatic pulse_rx(input logic [7:0] b, input int d);
    repeat (d) @(posedge clk);
    #1;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
  endtask

  initial begin
    int idx, code;
    logic [7:0] junk;
    bus.tx_idle = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    forever begin
      @(negedge clk);
      if (inject_cnt != inject_seen) begin
        inject_seen++;
        pulse_rx(8'hFA, 1);
      end else if (bus.wr_ps2) begin
        @(posedge clk);
        #1;
        bus.tx_idle = 1'b0;
        if (stuck) begin
          while (stuck) @(posedge clk);
          #1;
          bus.tx_idle = 1'b1;
        end else begin
          idx = frames - script_base;
          frames++;
          for (int k = 1; k < frame_len; k++) begin
            @(posedge clk);
            #1;
            bus.rx_done = stray && (k == frame_len / 2);
            if (bus.rx_done) bus.rx_data = 8'hFA;
          end
          bus.rx_done = 1'b0;
          bus.tx_idle = 1'b1;
          code = (idx < script_len) ? script[idx] : C_SIL;
          junk = 8'($urandom_range(0, 249));
          case (code)
            C_ACK:  pulse_rx(8'hFA, $urandom_range(1, 20));
            C_RES:  pulse_rx(8'hFE, $urandom_range(1, 20));
            C_JACK: begin pulse_rx(junk, $urandom_range(1, 10)); pulse_rx(8'hFA, $urandom_range(1, 10)); end
            C_JRES: begin pulse_rx(junk, $urandom_range(1, 10)); pulse_rx(8'hFE, $urandom_range(1, 10)); end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Attempt i succeeds iff the device answers it with 0xFA; a resend or
  // silence consumes one attempt; MR resends are allowed after the first.
  function automatic void model(output int launches, output bit ok);
    int code;
    launches = MR + 1;
    ok = 1'b0;
    for (int i = 0; i <= MR; i++) begin
      code = (i < script_len) ? script[i] : C_SIL;
      if (code == C_ACK || code == C_JACK) begin
        launches = i + 1;
        ok = 1'b1;
        break;
      end
    end
  endfunction

  // One command on one port; checks launch count, launched bytes, outcome.
  task automatic run_txn(input int port, input logic [7:0] c, input bit stuck_mode,
                         input string name, output int bl, output int lat);
    int  be, exp_l, got_l, exp_ev;
    bit  exp_ok, seen;
    logic busy_end;
    if (stuck_mode) begin
      exp_l = 1;
      exp_ok = 1'b0;
    end else begin
      model(exp_l, exp_ok);
    end
    exp_ev = port + (exp_ok ? 0 : 2);
    bl = launch_q.size();
    be = ev_q.size();
    script_base = frames;
    lat = -1;
    busy_end = 1'b0;
    @(posedge clk);
    #1;
    if (port == 0) begin req0 = 1'b1; cmd0 = c; end
    else begin req1 = 1'b1; cmd1 = c; end
    seen = 1'b0;
    for (int n = 0; n < BUDGET && !seen; n++) begin
      @(negedge clk);
      if (bus.wr_ps2 && lat < 0) lat = n;
      if (port == 0 && (done0 || err0)) begin seen = 1'b1; busy_end = busy; req0 = 1'b0; end
      if (port == 1 && (done1 || err1)) begin seen = 1'b1; busy_end = busy; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s completion: no done/err within %0d cycles", name, BUDGET);
    end
    checks++;
    if (busy_end !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_at_pulse: got %b want 1", name, busy_end);
    end
    got_l = launch_q.size() - bl;
    checks++;
    if (got_l !== exp_l) begin
      failures++;
      $display("FAIL %s launches: got %0d want %0d", name, got_l, exp_l);
    end
    for (int i = bl; i < launch_q.size(); i++) begin
      checks++;
      if (launch_q[i] !== c) begin
        failures++;
        $display("FAIL %s launch_cmd[%0d]: got %h want %h", name, i - bl, launch_q[i], c);
      end
    end
    checks++;
    if (ev_q.size() - be !== 1) begin
      failures++;
      $display("FAIL %s pulse_count: got %0d want 1", name, ev_q.size() - be);
    end else if (ev_q[be] !== exp_ev) begin
      failures++;
      $display("FAIL %s outcome: got event %0d want %0d", name, ev_q[be], exp_ev);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after: got %b want 0", name, busy);
    end
    checks++;
    if (wr_double !== 0 || pulse_long !== 0) begin
      failures++;
      $display("FAIL %s pulse_width: wr_double=%0d pulse_long=%0d want 0/0", name, wr_double, pulse_long);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_ps2, bus.cmd, done0, err0, done1, err1, busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_values: got wr=%b cmd=%h d0=%b e0=%b d1=%b e1=%b busy=%b want all 0",
               bus.wr_ps2, bus.cmd, done0, err0, done1, err1, busy);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int bl, lat;
    stray = 1'b0;
    frame_len = 200;
    script[0] = C_ACK;
    script_len = 1;
    run_txn(1, 8'hF4, 1'b0, "single", bl, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL single req_to_wr: got %0d edges want 2", lat);
    end
    checks++;
    if (last_done_cyc - last_ack_cyc !== 1) begin
      failures++;
      $display("FAIL single ack_to_done: got %0d cycles want 1", last_done_cyc - last_ack_cyc);
    end
  endtask

  task automatic test_priority();
    int bl, be, n;
    bit d0, d1;
    stray = 1'b0;
    frame_len = 50;
    script[0] = C_ACK;
    script[1] = C_ACK;
    script_len = 2;
    bl = launch_q.size();
    be = ev_q.size();
    script_base = frames;
    @(posedge clk);
    #1;
    req0 = 1'b1; cmd0 = 8'hFF;
    req1 = 1'b1; cmd1 = 8'hF4;
    d0 = 1'b0;
    d1 = 1'b0;
    for (n = 0; n < BUDGET && !(d0 && d1); n++) begin
      @(negedge clk);
      if (done0 || err0) begin d0 = 1'b1; req0 = 1'b0; end
      if (done1 || err1) begin d1 = 1'b1; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (launch_q.size() - bl !== 2) begin
      failures++;
      $display("FAIL priority launches: got %0d want 2", launch_q.size() - bl);
    end else begin
      checks++;
      if (launch_q[bl] !== 8'hFF || launch_q[bl+1] !== 8'hF4) begin
        failures++;
        $display("FAIL priority cmd_order: got %h,%h want ff,f4", launch_q[bl], launch_q[bl+1]);
      end
    end
    checks++;
    if (ev_q.size() - be !== 2) begin
      failures++;
      $display("FAIL priority pulses: got %0d want 2", ev_q.size() - be);
    end else begin
      checks++;
      if (ev_q[be] !== 0 || ev_q[be+1] !== 1) begin
        failures++;
        $display("FAIL priority done_order: got %0d,%0d want 0,1", ev_q[be], ev_q[be+1]);
      end
    end
  endtask

  task automatic test_resend();
    int bl, lat;
    stray = 1'b0;
    frame_len = 60;
    script[0] = C_RES;
    script[1] = C_RES;
    script[2] = C_ACK;
    script_len = 3;
    run_txn(0, 8'hED, 1'b0, "resend", bl, lat);
  endtask

  task automatic test_exhaust();
    int bl, lat, gap;
    stray = 1'b0;
    frame_len = 30;
    script_len = 0;
    run_txn(1, 8'($urandom), 1'b0, "exhaust", bl, lat);
    if (launch_q.size() - bl == MR + 1) begin
      for (int i = 1; i <= MR; i++) begin
        gap = launch_cyc[bl+i] - launch_cyc[bl+i-1];
        checks++;
        if (gap < T || gap > T + 3) begin
          failures++;
          $display("FAIL exhaust launch_gap[%0d]: got %0d want %0d..%0d", i, gap, T, T + 3);
        end
      end
      gap = last_err_cyc - launch_cyc[bl+MR];
      checks++;
      if (gap < T || gap > T + 2) begin
        failures++;
        $display("FAIL exhaust err_delay: got %0d want %0d..%0d", gap, T, T + 2);
      end
    end
  endtask

  task automatic test_stuck();
    int bl, lat, gap;
    stray = 1'b0;
    frame_len = 30;
    script_len = 0;
    stuck = 1'b1;
    run_txn(0, 8'($urandom), 1'b1, "stuck", bl, lat);
    if (launch_cyc.size() > bl) begin
      // the timer counts from the strobe cycle; err follows one cycle later
      gap = last_err_cyc - launch_cyc[bl];
      checks++;
      if (gap < T || gap > T + 2) begin
        failures++;
        $display("FAIL stuck err_delay: got %0d want %0d..%0d", gap, T, T + 2);
      end
    end
    stuck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bl, be;
    bit launched;
    stray = 1'b0;
    frame_len = 40;
    script_len = 0;
    bl = launch_q.size();
    be = ev_q.size();
    script_base = frames;
    @(posedge clk);
    #1;
    req1 = 1'b1;
    cmd1 = 8'h5A;
    launched = 1'b0;
    for (int n = 0; n < 100 && !launched; n++) begin
      @(negedge clk);
      launched = launch_q.size() > bl;
    end
    checks++;
    if (!launched) begin
      failures++;
      $display("FAIL reset_mid launch: got none want 1");
    end
    repeat (frame_len + 10) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_ps2, bus.cmd, done0, err0, done1, err1, busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_mid outputs: got wr=%b cmd=%h d0=%b e0=%b d1=%b e1=%b busy=%b want all 0",
               bus.wr_ps2, bus.cmd, done0, err0, done1, err1, busy);
    end
    rst = 1'b1;
    inject_cnt++;
    repeat (40) @(negedge clk);
    checks++;
    if (ev_q.size() !== be || busy !== 1'b0 || launch_q.size() - bl !== 1) begin
      failures++;
      $display("FAIL reset_mid quiet: got pulses=%0d busy=%b launches=%0d want 0/0/1",
               ev_q.size() - be, busy, launch_q.size() - bl);
    end
  endtask

  task automatic test_random();
    int bl, lat, r;
    for (int t = 0; t < 6; t++) begin
      frame_len = $urandom_range(10, 120);
      stray = 1'($urandom_range(0, 1));
      script_len = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        script[i] = (r == 0) ? C_SIL : (r <= 3) ? C_ACK : (r <= 6) ? C_RES : (r == 7) ? C_JACK : C_JRES;
      end
      run_txn($urandom_range(0, 1), 8'($urandom), 1'b0, "random", bl, lat);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_resend();
    test_exhaust();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
